// File: rtl/tx_frame_loader.sv
// Collects a host frame payload, writes length + payload into the tx buffer, pulses start and
// waits for TX_EVENT_END. Optional TX watchdog is enabled by defining TX_LOADER_WDT_EN.
module tx_frame_loader #(
  parameter int         MAX_LEN      = 122,
  parameter int         FCS_LEN      = 2,
  parameter int         WDT_CYCLES   = 1000000,
  parameter logic [2:0] TX_EVENT_END = 3'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_buf_w_en,
  output logic [6:0] o_buf_w_addr,
  output logic [7:0] o_buf_byte,
  output logic       o_start,
  input  logic [2:0] i_ev,
  input  logic       i_ev_sig,
  output logic       o_busy,
  output logic       o_drop,
  output logic       o_timeout
);

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_DISCARD = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_TX      = 3'd4;

  localparam logic [7:0]  MAX_B    = MAX_LEN[7:0];
  localparam logic [7:0]  FCS_B    = FCS_LEN[7:0];
  localparam logic [19:0] WDT_LAST = 20'(WDT_CYCLES - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic [7:0] r_mem [MAX_LEN];

  logic       w_accept;
  logic       w_overflow;
  logic       w_store;
  logic       w_end;
  logic       w_timeout;
  logic [6:0] w_wr_idx;
  logic [6:0] w_rd_idx;
  logic [7:0] w_rd_byte;

  assign o_ready    = (r_state == ST_COLLECT) || (r_state == ST_DISCARD);
  assign o_busy     = (r_state == ST_LOAD) || (r_state == ST_START) || (r_state == ST_TX);
  assign w_accept   = i_valid & o_ready;
  assign w_overflow = (r_cnt == MAX_B);
  assign w_store    = w_accept && (r_state == ST_COLLECT) && !w_overflow;
  assign w_end      = i_ev_sig && (i_ev == TX_EVENT_END);
  assign w_wr_idx   = r_cnt[6:0];
  // buffer address k carries payload byte k-1
  assign w_rd_idx   = r_idx[6:0] - 7'd1;
  assign w_rd_byte  = r_mem[w_rd_idx];

`ifdef TX_LOADER_WDT_EN
  logic [19:0] r_wdt;

  assign w_timeout = (r_state == ST_TX) && !w_end && (r_wdt == WDT_LAST);

  // counter sits at zero outside TX, so it starts from zero on every TX entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdt <= 20'd0;
    end else if (r_state != ST_TX) begin
      r_wdt <= 20'd0;
    end else begin
      r_wdt <= r_wdt + 20'd1;
    end
  end
`else
  logic w_unused_wdt;

  assign w_timeout    = 1'b0;
  assign w_unused_wdt = ^WDT_LAST;
`endif

  // payload memory is deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_COLLECT;
      r_cnt        <= 8'd0;
      r_len        <= 8'd0;
      r_idx        <= 8'd0;
      o_buf_w_en   <= 1'b0;
      o_buf_w_addr <= 7'd0;
      o_buf_byte   <= 8'd0;
      o_start      <= 1'b0;
      o_drop       <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_start   <= 1'b0;
      o_drop    <= 1'b0;
      o_timeout <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (w_overflow) begin
              if (i_last) begin
                o_drop <= 1'b1;
                r_cnt  <= 8'd0;
              end else begin
                r_state <= ST_DISCARD;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
              if (i_last) begin
                // length byte goes out on the same edge the frame closes
                r_len        <= r_cnt + 8'd1;
                r_idx        <= 8'd1;
                o_buf_w_en   <= 1'b1;
                o_buf_w_addr <= 7'd0;
                o_buf_byte   <= r_cnt + 8'd1 + FCS_B;
                r_state      <= ST_LOAD;
              end
            end
          end
        end
        ST_DISCARD: begin
          if (w_accept && i_last) begin
            o_drop  <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= ST_COLLECT;
          end
        end
        ST_LOAD: begin
          if (r_idx <= r_len) begin
            o_buf_w_en   <= 1'b1;
            o_buf_w_addr <= r_idx[6:0];
            o_buf_byte   <= w_rd_byte;
            r_idx        <= r_idx + 8'd1;
          end else begin
            o_buf_w_en <= 1'b0;
            o_start    <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          r_state <= ST_TX;
        end
        ST_TX: begin
          if (w_end) begin
            r_cnt   <= 8'd0;
            r_state <= ST_COLLECT;
          end else if (w_timeout) begin
            o_timeout <= 1'b1;
            r_cnt     <= 8'd0;
            r_state   <= ST_COLLECT;
          end
        end
        default: begin
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_loader.sv
// Randomized scoreboard bench for tx_frame_loader: driver pushes expected buffer writes,
// start/drop/timeout pulses with their cycle numbers; a monitor pops and compares.
module tb_tx_frame_loader;

  localparam int         MAX_LEN = 122;
  localparam int         FCS_LEN = 2;
  localparam int         WDT     = 100;
  localparam logic [2:0] EV_END  = 3'd1;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] i_data   = 8'h00;
  logic       i_valid  = 1'b0;
  logic       i_last   = 1'b0;
  logic [2:0] i_ev     = 3'd0;
  logic       i_ev_sig = 1'b0;
  logic       o_ready;
  logic       o_buf_w_en;
  logic [6:0] o_buf_w_addr;
  logic [7:0] o_buf_byte;
  logic       o_start;
  logic       o_busy;
  logic       o_drop;
  logic       o_timeout;

  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  wr_t wq[$];
  int  sq[$];
  int  dq[$];
  int  tq[$];

  tx_frame_loader #(
    .MAX_LEN(MAX_LEN), .FCS_LEN(FCS_LEN), .WDT_CYCLES(WDT), .TX_EVENT_END(EV_END)
  ) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_buf_w_en(o_buf_w_en), .o_buf_w_addr(o_buf_w_addr),
    .o_buf_byte(o_buf_byte), .o_start(o_start), .i_ev(i_ev), .i_ev_sig(i_ev_sig),
    .o_busy(o_busy), .o_drop(o_drop), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: a frame of n bytes either loads (n+1 writes, start one cycle later) or is dropped.
  task automatic push_expect(input bq_t pl, input int nacc);
    int  n;
    wr_t e;
    n = pl.size();
    if (n > MAX_LEN) begin
      dq.push_back(nacc);
    end else begin
      e = '{nacc, 0, n + FCS_LEN};
      wq.push_back(e);
      for (int k = 1; k <= n; k++) begin
        e = '{nacc + k, k, int'(pl[k-1])};
        wq.push_back(e);
      end
      sq.push_back(nacc + n + 1);
    end
  endtask

  task automatic accept_byte(input logic [7:0] d, input logic l, input int gap, output int nacc);
    int budget;
    budget = 0;
    for (int g = 0; g < gap; g++) begin
      i_valid  = 1'b0;
      i_ev_sig = 1'($urandom_range(0, 1));
      i_ev     = EV_END;
      @(negedge clk);
    end
    i_ev_sig = 1'b0;
    i_valid  = 1'b1;
    i_data   = d;
    i_last   = l;
    while (!o_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 300) chk("ready_timeout", int'(o_ready), 1);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    nacc    = cyc;
  endtask

  task automatic expect_frame(input bq_t pl, input int nacc, input bit bp,
                              input logic [7:0] hold, output int endc);
    int         n;
    int         tw;
    logic [2:0] ev;
    n    = pl.size();
    endc = nacc;
    push_expect(pl, nacc);
    if (n > MAX_LEN) begin
      chk("ready_after_drop", int'(o_ready), 1);
      return;
    end
    tw = int'($urandom_range(1, 6));
    for (int j = 0; j < n + 2 + tw; j++) begin
      chk("ready_low_while_busy", int'(o_ready), 0);
      chk("busy_high", int'(o_busy), 1);
      if (bp) begin
        i_valid = 1'b1;
        i_data  = hold;
        i_last  = 1'b1;
      end
      if (j >= n + 2) begin
        do ev = 3'($urandom_range(0, 7)); while (ev == EV_END);
        i_ev     = ev;
        i_ev_sig = 1'($urandom_range(0, 1));
      end else begin
        i_ev     = EV_END;
        i_ev_sig = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
    end
    i_ev_sig = 1'b1;
    i_ev     = EV_END;
    @(negedge clk);
    i_ev_sig = 1'b0;
    chk("ready_after_end", int'(o_ready), 1);
    chk("busy_after_end", int'(o_busy), 0);
    endc = cyc;
  endtask

  task automatic send_frame(input bq_t pl, input int maxgap, input bit bp);
    int         nacc;
    int         endc;
    int         n2;
    bq_t        q1;
    logic [7:0] hold;
    hold = 8'($urandom);
    nacc = 0;
    for (int i = 0; i < pl.size(); i++) begin
      accept_byte(pl[i], (i == pl.size() - 1), int'($urandom_range(0, maxgap)), nacc);
    end
    expect_frame(pl, nacc, bp, hold, endc);
    if (bp && pl.size() <= MAX_LEN) begin
      accept_byte(hold, 1'b1, 0, n2);
      chk("bp_first_accept_cycle", n2, endc + 1);
      q1.push_back(hold);
      expect_frame(q1, n2, 1'b0, hold, endc);
    end
  endtask

  task automatic reset_mid_load();
    bq_t pl;
    int  nacc;
    wr_t e;
    nacc = 0;
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    for (int i = 0; i < 10; i++) accept_byte(pl[i], (i == 9), 0, nacc);
    e = '{nacc, 0, 10 + FCS_LEN};
    wq.push_back(e);
    e = '{nacc + 1, 1, int'(pl[0])};
    wq.push_back(e);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_wen", int'(o_buf_w_en), 0);
    chk("rst_mid_ready", int'(o_ready), 1);
    chk("rst_mid_busy", int'(o_busy), 0);
    chk("rst_mid_start", int'(o_start), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  // monitor: every output event must match the head of its expectation queue
  initial begin
    wr_t e;
    int  x;
    forever begin
      @(negedge clk);
      #1;
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        e = wq.pop_front();
        chk("wr_missing_addr", -1, e.addr);
      end
      while (sq.size() > 0 && sq[0] < cyc) begin
        x = sq.pop_front();
        chk("start_missing_cycle", -1, x);
      end
      while (dq.size() > 0 && dq[0] < cyc) begin
        x = dq.pop_front();
        chk("drop_missing_cycle", -1, x);
      end
      while (tq.size() > 0 && tq[0] < cyc) begin
        x = tq.pop_front();
        chk("timeout_missing_cycle", -1, x);
      end
      if (o_buf_w_en) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected_addr", int'(o_buf_w_addr), -1);
        end else begin
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", int'(o_buf_w_addr), e.addr);
          chk("wr_data", int'(o_buf_byte), e.data);
        end
      end
      if (o_start) begin
        if (sq.size() == 0) chk("start_unexpected", 1, 0);
        else chk("start_cycle", cyc, sq.pop_front());
      end
      if (o_drop) begin
        if (dq.size() == 0) chk("drop_unexpected", 1, 0);
        else chk("drop_cycle", cyc, dq.pop_front());
      end
      if (o_timeout) begin
        if (tq.size() == 0) chk("timeout_unexpected", 1, 0);
        else chk("timeout_cycle", cyc, tq.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "tb_tx_frame_loader aborted");
  end

  initial begin
    bq_t pl;
    int  len;
    int  nacc;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_wen", int'(o_buf_w_en), 0);
    chk("rst_addr", int'(o_buf_w_addr), 0);
    chk("rst_byte", int'(o_buf_byte), 0);
    chk("rst_start", int'(o_start), 0);
    chk("rst_drop", int'(o_drop), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    reset = 1'b0;
    @(negedge clk);

    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(pl, 0, 1'b0);

    pl.delete();
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(i));
    send_frame(pl, 0, 1'b0);

    pl.delete();
    for (int i = 0; i < 124; i++) pl.push_back(8'($urandom));
    send_frame(pl, 0, 1'b0);
    pl = '{8'h5A};
    send_frame(pl, 1, 1'b0);

    pl.delete();
    for (int i = 0; i < MAX_LEN + 1; i++) pl.push_back(8'($urandom));
    send_frame(pl, 1, 1'b0);
    pl = '{8'h12, 8'h34};
    send_frame(pl, 0, 1'b0);

    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(pl, 0, 1'b1);

    reset_mid_load();
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55};
    send_frame(pl, 0, 1'b0);

    repeat (16) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(118, 126))
                                        : int'($urandom_range(1, 12));
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      send_frame(pl, 2, 1'($urandom_range(0, 1)));
    end

`ifdef TX_LOADER_WDT_EN
    pl = '{8'h11};
    accept_byte(8'h11, 1'b1, 0, nacc);
    push_expect(pl, nacc);
    tq.push_back(nacc + 3 + WDT);
    while (cyc < nacc + 3 + WDT) @(negedge clk);
    chk("ready_after_timeout", int'(o_ready), 1);
    pl = '{8'h77, 8'h88};
    send_frame(pl, 0, 1'b0);
`else
    nacc = 0;
`endif

    repeat (10) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("sq_drained", sq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    chk("tq_drained", tq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_loader.md
# tx_frame_loader

Upstream feeder for the `tx` block. It accepts a variable-length frame payload as a byte stream from a host-side source such as a UART receiver or command decoder. It writes the length byte and then the payload into the TX buffer through the buffer-write interface, pulses start, and holds off new input until `tx` reports `TX_EVENT_END`. This replaces hard-wired frame contents with host-supplied frames.

## Interface
- `MAX_LEN`, 122: maximum payload bytes per frame; must be at most 125.
- `FCS_LEN`, 2: FCS bytes added by `tx`; included in the length byte.
- `WDT_CYCLES`, 1000000: watchdog limit in cycles; 20-bit; only used with the macro.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_data`  in  8  payload byte.
- `i_valid`  in  1  `i_data` is valid.
- `i_last`  in  1  qualifies the final byte of the frame; sampled with `i_valid`.
- `o_ready`  out  1  block accepts a byte this cycle.
- `o_buf_w_en`  out  1  TX buffer write enable.
- `o_buf_w_addr`  out  7  TX buffer write address.
- `o_buf_byte`  out  8  TX buffer write data.
- `o_start`  out  1  one-cycle transmit start pulse to `tx`.
- `i_ev`  in  3  `tx` event code, using the `tx.vh` encoding.
- `i_ev_sig`  in  1  `i_ev` is valid this cycle.
- `o_busy`  out  1  high in LOAD, START and TX.
- `o_drop`  out  1  one-cycle pulse when an oversize frame is discarded.
- `o_timeout`  out  1  one-cycle watchdog pulse; tied 0 without the macro.

## Operation
- A byte is accepted on any rising edge where `i_valid & o_ready` is high.
- Internal storage: `MAX_LEN`×8 payload memory and an 8-bit byte count `cnt`.
- **COLLECT** (reset state), `o_ready`=1:
  - An accepted byte is stored at `mem[cnt]` and `cnt` increments.
  - If that byte has `i_last`=1, the frame length is latched as `len` = `cnt`+1 and the state goes to LOAD.
  - If a byte is accepted while `cnt`==`MAX_LEN`, it is an overflow. If that byte also has `i_last`=1, pulse `o_drop`, clear `cnt` and stay in COLLECT. Otherwise go to DISCARD.
- **DISCARD**, `o_ready`=1: swallow bytes until a byte with `i_last`=1 is accepted. Then pulse `o_drop`, clear `cnt` and return to COLLECT.
- **LOAD**, `o_ready`=0: write `len`+1 consecutive buffer entries.
  - First write: address 0, data `len`+`FCS_LEN`.
  - Next writes: address k, data `mem[k-1]`, for k = 1..`len`.
  - After the last write, `o_buf_w_en` drops to 0 and the state goes to START.
- **START**: `o_start`=1 for exactly one cycle, then go to TX.
- **TX**: wait for `i_ev_sig` with `i_ev`==`TX_EVENT_END`, then clear `cnt` and return to COLLECT.
  - Other events in TX are ignored.
  - `i_ev_sig` in any state other than TX is ignored.
- Frame length is always at least 1, because `i_last` travels with a byte.

## Timing
- All outputs are registered except `o_ready` and `o_busy`, which are decoded from the state.
- Reset values (state forced to COLLECT):
  - `o_buf_w_en`, `o_buf_w_addr`, `o_buf_byte`, `o_start`, `o_drop`, `o_timeout`, `o_busy` = 0.
  - `o_ready` = 1.
- Latency, with the last byte accepted on edge N:
  - `o_buf_w_en` is high for cycles N+1 through N+1+`len`; address 0 appears in cycle N+1.
  - `o_start` is high in cycle N+`len`+2.
- COLLECT is re-entered on the edge that samples `TX_EVENT_END`; a byte can be accepted on the following edge.
- Reset asserted mid-operation: all outputs go to their reset values immediately.
  - The partial frame is lost and no `o_start` is issued.
  - The payload memory is not cleared.

## Configuration
- Macro: `TX_LOADER_WDT_EN`.
- Defined:
  - A 20-bit counter clears on entry to TX and increments each TX cycle.
  - Reaching `WDT_CYCLES` without `TX_EVENT_END` pulses `o_timeout` for one cycle and returns to COLLECT with `cnt` cleared.
- Undefined: no counter; `o_timeout` is constant 0, and TX waits indefinitely for `TX_EVENT_END`.

## Test plan
- **Short frame:** send AA, BB, CC with `i_last` on CC. Required: writes (0,0x05), (1,AA), (2,BB), (3,CC) on consecutive cycles, `o_start` one cycle later, `o_ready`=0 until `TX_EVENT_END`.
- **Maximum frame:** 122 bytes 0x00..0x79 with `i_last` on the final byte. Required: length byte 124 at address 0, data at addresses 1..122, a single `o_start`.
- **Overflow:** 124 bytes with `i_last` only on the 124th. Required: no buffer writes, one `o_drop` pulse after the 124th byte; a following 1-byte frame 0x5A loads (0,0x03), (1,0x5A).
- **Back-pressure:** hold `i_valid`=1 throughout TX. Required: no byte accepted in LOAD/START/TX; the first byte is accepted on the edge after the `TX_EVENT_END` sample.
- **Reset mid-LOAD:** assert `reset` during the 3rd write of a 10-byte frame. Required: `o_buf_w_en`=0 immediately, no `o_start`; the next frame loads normally.
- **Watchdog:** with `TX_LOADER_WDT_EN` defined and `WDT_CYCLES`=100, withhold `TX_EVENT_END`. Required: `o_timeout` pulses 100 cycles after TX entry and `o_ready` returns to 1.
